// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: instruction opcodes, ALU opcodes and FSM states.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StDecode,
    StRead,
    StExecute,
    StWrite,
    StHalted
  } state_e;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLoad  = 4'h1;
  localparam logic [3:0] OpStore = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpAnd   = 4'h5;
  localparam logic [3:0] OpOr    = 4'h6;
  localparam logic [3:0] OpXor   = 4'h7;
  localparam logic [3:0] OpJump  = 4'h8;
  localparam logic [3:0] OpJz    = 4'h9;
  localparam logic [3:0] OpShl   = 4'hA;
  localparam logic [3:0] OpShr   = 4'hB;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b1000;
  localparam logic [3:0] AluOr  = 4'b1001;
  localparam logic [3:0] AluXor = 4'b1010;
  localparam logic [3:0] AluShl = 4'b0100;
  localparam logic [3:0] AluShr = 4'b0101;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decode: routing flags for the sequencer FSM and the ALU opcode.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OPC = OpHalt
) (
  input  logic [3:0] opcode,
  output logic       is_load,
  output logic       is_read,
  output logic       is_write,
  output logic       is_jump,
  output logic       is_jz,
  output logic       is_halt,
  output logic [3:0] alu_op
);

  always_comb begin
    is_load  = 1'b0;
    is_read  = 1'b0;
    is_write = 1'b0;
    is_jump  = 1'b0;
    is_jz    = 1'b0;
    is_halt  = 1'b0;
    alu_op   = AluAdd;
    // The halt opcode is configurable, so it takes priority over the fixed map.
    if (opcode == HALT_OPC) begin
      is_halt = 1'b1;
    end else begin
      case (opcode)
        OpLoad:  begin is_load = 1'b1; is_read = 1'b1; end
        OpStore: is_write = 1'b1;
        OpAdd:   begin is_read = 1'b1; alu_op = AluAdd; end
        OpSub:   begin is_read = 1'b1; alu_op = AluSub; end
        OpAnd:   begin is_read = 1'b1; alu_op = AluAnd; end
        OpOr:    begin is_read = 1'b1; alu_op = AluOr;  end
        OpXor:   begin is_read = 1'b1; alu_op = AluXor; end
        OpShl:   begin is_read = 1'b1; alu_op = AluShl; end
        OpShr:   begin is_read = 1'b1; alu_op = AluShr; end
        OpJump:  is_jump = 1'b1;
        OpJz:    is_jz = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Accumulator-machine control sequencer with external memory and ALU.
// Define CTRL_INSTR_COUNT_EN to build the retired-instruction counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        halted,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [15:0] acc,
  output logic [11:0] pc,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] ir_q, ir_d;

  logic [11:0] ir_addr;
  logic        is_load, is_read, is_write, is_jump, is_jz, is_halt;

  assign ir_addr = ir_q[11:0];

  ctrl_decoder #(
    .HALT_OPC (HALT_OPC)
  ) u_decoder (
    .opcode   (ir_q[15:12]),
    .is_load  (is_load),
    .is_read  (is_read),
    .is_write (is_write),
    .is_jump  (is_jump),
    .is_jz    (is_jz),
    .is_halt  (is_halt),
    .alu_op   (alu_op)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = StLatch;
      StLatch:   state_d = StDecode;
      StDecode: begin
        if (is_halt)       state_d = StHalted;
        else if (is_read)  state_d = StRead;
        else if (is_write) state_d = StWrite;
        else               state_d = StFetch;
      end
      StRead:    state_d = StExecute;
      StExecute: state_d = StFetch;
      StWrite:   state_d = StFetch;
      StHalted:  state_d = StHalted;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    ir_d  = ir_q;
    case (state_q)
      StLatch: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 12'd1;
      end
      StDecode: begin
        if (is_jump || (is_jz && acc_q == 16'h0000)) pc_d = ir_addr;
      end
      StExecute: acc_d = is_load ? mem_rdata : alu_result;
      default: ;
    endcase
  end

  // Memory outputs are decoded from state so reset clears them without a clock.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      StFetch: mem_addr = {4'b0000, pc_q};
      StRead:  mem_addr = {4'b0000, ir_addr};
      StWrite: begin
        mem_addr  = {4'b0000, ir_addr};
        mem_wdata = acc_q;
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == StHalted);
  assign alu_a  = acc_q;
  assign alu_b  = mem_rdata;
  assign acc    = acc_q;
  assign pc     = pc_q;

`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] count_q;
  logic        retire;

  // Non-memory instructions (NOP/JUMP/JZ/HALT) retire in DECODE.
  assign retire = (state_q == StExecute) || (state_q == StWrite) ||
                  ((state_q == StDecode) && !is_read && !is_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPC, default 4'hF, meaning the opcode that enters HALTED.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  leave IDLE; halted  out  1  high in HALTED.
REQ-005 SHALL have memory initiator ports: mem_addr  out  16  word address; mem_wdata  out  16  write data; mem_we  out  1  write strobe; mem_rdata  in  16  read data, valid one cycle after address.
REQ-006 SHALL have ALU ports: alu_op  out  4  ALU opcode; alu_a  out  16  equals acc; alu_b  out  16  equals mem_rdata; alu_result  in  16  combinational result.
REQ-007 SHALL have status ports: acc  out  16  accumulator; pc  out  12  program counter; instr_count  out  16  retired-instruction count.

Function
REQ-008 SHALL decode the instruction as opcode = IR[15:12], address = IR[11:0], with mem_addr = {4'b0, address-or-PC}.
REQ-009 SHALL implement these opcodes: 0 NOP; 1 LOAD (acc<=M[a]); 2 STORE (M[a]<=acc); 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR; 8 JUMP; 9 JZ; A SHL; B SHR; F HALT; all other opcodes execute as NOP.
REQ-010 SHALL drive alu_op 0000/0001/1000/1001/1010/0100/0101 for ADD/SUB/AND/OR/XOR/SHL/SHR respectively, and 0000 otherwise.
REQ-011 SHALL have the states IDLE, FETCH, LATCH, DECODE, READ, EXECUTE, WRITE and HALTED.
REQ-012 SHALL transition IDLE->FETCH when start=1; start SHALL be ignored in every other state.
REQ-013 SHALL in FETCH drive mem_addr=pc with mem_we=0, then go to LATCH.
REQ-014 SHALL in LATCH load IR<=mem_rdata and pc<=pc+1 (mod 4096, 12'hFFF wraps to 12'h000), then go to DECODE.
REQ-015 SHALL in DECODE route as follows: LOAD and ALU ops->READ; STORE->WRITE; JUMP->FETCH with pc<=a; JZ->FETCH with pc<=a only when acc==0; NOP/illegal->FETCH; HALT->HALTED.
REQ-016 SHALL in READ drive mem_addr=a with mem_we=0, then go to EXECUTE.
REQ-017 SHALL in EXECUTE load acc<=mem_rdata for LOAD and acc<=alu_result for ALU ops, then go to FETCH.
REQ-018 SHALL in WRITE drive mem_addr=a, mem_wdata=acc and mem_we=1 for exactly this one cycle, then go to FETCH.
REQ-019 SHALL hold mem_we=0 in every state except WRITE.
REQ-020 SHALL have fixed latencies, FETCH-entry to next FETCH-entry: LOAD/ALU 5 cycles; STORE 4; NOP/JUMP/JZ 3.
REQ-021 SHALL discard ALU overflow and carry; 16-bit wrap-around is the defined result.
REQ-022 SHALL remain in HALTED, with halted=1 and no memory access, until reset.
REQ-023 SHALL count instr_count once per retired instruction, including HALT, and wrap at 16'hFFFF.

Reset
REQ-024 SHALL on reset_n=0 immediately force state=IDLE, pc=RESET_PC, acc=0, IR=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0 and instr_count=0, independent of clk.
REQ-025 SHALL abort any instruction when reset is asserted mid-instruction, with no partial acc/pc update and no write strobe after assertion.

Configuration
REQ-026 SHALL, when CTRL_INSTR_COUNT_EN is defined, implement the instr_count counter per REQ-023.
REQ-027 SHALL, when CTRL_INSTR_COUNT_EN is undefined, tie instr_count to 16'h0000 with no counter flops.

Structure
REQ-028 SHALL take the opcode constants, ALU opcode constants and state encoding from shared package ctrl_pkg.
REQ-029 SHALL place the opcode-to-route and opcode-to-alu_op mapping in one combinational sub-module, ctrl_decoder.

Verification
REQ-030 SHALL cover: M[0]=1005, M[5]=0x0007, start -> acc=0x0007 on cycle 5 after FETCH, pc=1.
REQ-031 SHALL cover: program LOAD 5, ADD 6, STORE 7, HALT with M[5]=0xFFFF, M[6]=0x0002 -> M[7]=0x0001 with mem_we high exactly one cycle, halted=1, instr_count=4.
REQ-032 SHALL cover: acc=0, JZ 0x020 at pc=3 -> next fetch address 0x020; same test with acc=1 -> next fetch address 0x004.
REQ-033 SHALL cover: pc=0xFFF executing NOP -> next fetch address 0x000.
REQ-034 SHALL cover: reset_n pulsed low during WRITE -> mem_we falls within the same cycle, state=IDLE, and memory is unchanged after release.
REQ-035 SHALL cover: opcode 0xC and start pulses while running -> treated as NOP (3 cycles), acc unchanged, no state disturbance.
